// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART byte receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; i_restart re-phases it to the current cycle.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-entry holding register,
// valid/ready handshake and frame-error / overrun pulses.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 128_000
) (
  input  logic       clock,
  input  logic       fpga_rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_byte_rx: CLK_FREQ/(BAUD*16) must be at least 2");
  end

  logic                 r_rx_p0;
  logic                 r_rx_s;
  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [OS_W-1:0]      r_os_cnt;
  logic [OS_W-1:0]      w_os_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_restart;
  logic                 w_tick;
  logic                 w_deliver;
  logic                 w_bad_stop;
  logic                 w_hs;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  // Stage p0 -> s: two-flop synchronizer, idles high
  always_ff @(posedge clock or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_rx_p0 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_rx_p0 <= rx;
      r_rx_s  <= r_rx_p0;
    end
  end

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .i_clk    (clock),
    .i_rst    (fpga_rst),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clock or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_state   <= ST_IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_os_cnt_nxt  = r_os_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_restart     = 1'b0;
    w_deliver     = 1'b0;
    w_bad_stop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt   = ST_START;
          w_restart     = 1'b1;
          w_os_cnt_nxt  = '0;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_START: begin
        // Half a bit in: confirm the start bit is still low
        if (w_tick) begin
          if (r_os_cnt == OS_HALF) begin
            w_os_cnt_nxt = '0;
            w_state_nxt  = r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            w_os_cnt_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_cnt_nxt  = '0;
            w_shift_nxt   = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = ST_STOP;
            end
          end else begin
            w_os_cnt_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_cnt_nxt = '0;
            if (r_rx_s) begin
              w_deliver   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_bad_stop  = 1'b1;
              w_state_nxt = ST_WAIT_IDLE;
            end
          end else begin
            w_os_cnt_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (r_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_hs = r_rx_valid && rx_ready;

  // Holding register: a delivery only lands if the slot is empty or being drained this cycle
  always_ff @(posedge clock or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad_stop;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_rx_valid || w_hs) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: frames are driven bit by bit, expected
// events are queued at stimulus time and matched by a monitor on the outputs.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CLKS = DIV * 16;
  // start edge -> middle of stop bit (9.5 bits) plus the synchronizer
  localparam int LAT      = 9 * BIT_CLKS + BIT_CLKS / 2 + 2;

  localparam int EV_NONE = 0;
  localparam int EV_DATA = 1;
  localparam int EV_FERR = 2;
  localparam int EV_OVR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t_exp;
  } exp_t;

  exp_t sb_q[$];

  logic       clock    = 1'b0;
  logic       fpga_rst = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clock    (clock),
    .fpga_rst (fpga_rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_DATA: return "data";
      EV_FERR: return "frame_err";
      EV_OVR:  return "overrun";
      default: return "none";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input int kind, input logic [7:0] data);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got data=%0h at cycle %0d, expected no event",
               kname(kind), data, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.data !== data ||
          cyc < e.t_exp - DIV || cyc > e.t_exp + DIV) begin
        bad++;
        $display("FAIL sb_%s: got %s data=%0h cycle=%0d, expected %s data=%0h cycle=%0d+-%0d",
                 kname(e.kind), kname(kind), data, cyc, kname(e.kind), e.data, e.t_exp, DIV);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (!fpga_rst) begin
        if (frame_err) sb_check(EV_FERR, 8'h00);
        if (overrun) sb_check(EV_OVR, rx_data);
        if (rx_valid && (!prev_valid || prev_hs)) sb_check(EV_DATA, rx_data);
      end
      prev_valid = rx_valid;
      prev_hs    = rx_valid & rx_ready;
    end
  endtask

  // Drive start, 8 data bits LSB first and the stop bit; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort,
                            input int kind, input logic [7:0] exp_data);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop, d, 1'b0};
    @(posedge clock); #1;
    if (kind != EV_NONE) begin
      e.kind  = kind;
      e.data  = exp_data;
      e.t_exp = cyc + LAT;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 10 * BIT_CLKS; i++) begin
      if (abort >= 0 && i == abort) return;
      rx = bits[i / BIT_CLKS];
      @(posedge clock); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    fork
      monitor();
      begin
        repeat (80000) @(posedge clock);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "timeout");
      end
    join_none

    fpga_rst = 1'b1;
    idle(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    fpga_rst = 1'b0;
    idle(20);

    // Clean 0xA5 frame with the consumer always ready
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, -1, EV_DATA, 8'hA5);
    idle(40);
    check("a5_valid_single", rx_valid, 0);
    check("a5_busy_idle", busy, 0);

    // 40-clock glitch must be rejected
    rx = 1'b0;
    idle(40);
    check("glitch_busy_mid", busy, 1);
    rx = 1'b1;
    idle(150);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_valid", rx_valid, 0);

    // Bad stop bit followed by a long low line
    send_frame(8'h3C, 1'b0, -1, EV_FERR, 8'h00);
    idle(300);
    check("ferr_busy_low", busy, 1);
    check("ferr_no_valid", rx_valid, 0);
    rx = 1'b1;
    idle(6);
    check("ferr_busy_released", busy, 0);
    idle(50);

    // Back-to-back with no consumer: second byte is dropped
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, EV_DATA, 8'h11);
    send_frame(8'h22, 1'b1, -1, EV_OVR, 8'h11);
    idle(20);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    check("ovr_popped", rx_valid, 0);
    idle(50);

    // Pop coinciding with the second delivery
    send_frame(8'h11, 1'b1, -1, EV_DATA, 8'h11);
    fork
      send_frame(8'h22, 1'b1, -1, EV_DATA, 8'h22);
      begin
        @(posedge clock); #1;
        repeat (LAT) @(posedge clock);
        #1 rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
      end
    join
    idle(20);
    check("coinc_valid", rx_valid, 1);
    check("coinc_data", rx_data, 8'h22);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h77, 1'b1, 600, EV_NONE, 8'h00);
    check("mid_busy", busy, 1);
    #2 fpga_rst = 1'b1;
    #1;
    check("arst_rx_valid", rx_valid, 0);
    check("arst_rx_data", rx_data, 0);
    check("arst_frame_err", frame_err, 0);
    check("arst_overrun", overrun, 0);
    check("arst_busy", busy, 0);
    rx = 1'b1;
    idle(5);
    fpga_rst = 1'b0;
    rx_ready = 1'b1;
    idle(30);
    check("post_rst_busy", busy, 0);
    send_frame(8'h5A, 1'b1, -1, EV_DATA, 8'h5A);
    idle(40);

    // Randomized frames against the rule: good stop -> byte, bad stop -> frame_err
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, -1, rs ? EV_DATA : EV_FERR, rs ? rb : 8'h00);
      rx = 1'b1;
      idle($urandom_range(1, 200));
    end

    idle(300);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
